// File: rtl/multi_state_seq_if.sv
// Handshake bundle between the multi-cycle main decoder (master) and the
// step sequencer (slave): control inputs, the 3-bit step and status/counters.
interface multi_state_seq_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [5:0]       Op;
  logic             next_ins;
  logic             mem_ready;
  logic [2:0]       state;
  logic             ctrl_kill;
  logic             ins_done;
  logic             illegal;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output run, Op, next_ins, mem_ready,
    input  state, ctrl_kill, ins_done, illegal, timeout, cycle_cnt, instr_cnt
  );

  modport slave (
    input  run, Op, next_ins, mem_ready,
    output state, ctrl_kill, ins_done, illegal, timeout, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/multi_state_seq.sv
// Step sequencer for the multi-cycle MIPS CPU: owns the IF/ID/EX/MEM/WB/HALT step,
// memory stalls, illegal-opcode trap and cycle/retire counters.
// Optional stall watchdog enabled by defining MULTI_STATE_SEQ_STALL_TIMEOUT_EN.
module multi_state_seq #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  multi_state_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } step_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  step_t            state_q;
  logic             illegal_q;
  logic             ins_done_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;

  logic mem_step;
  logic legal_op;
  logic legal_step;
  logic stalled;
  logic advance;
  logic retire;
  logic trap_illegal;
  logic trap_timeout;

  assign mem_step   = (state_q == S_IF) ||
                      (state_q == S_MEM && (bus.Op == OP_LW || bus.Op == OP_SW));
  assign legal_op   = bus.Op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  assign legal_step = state_q inside {S_IF, S_ID, S_EX, S_MEM, S_WB};
  assign stalled    = bus.run && mem_step && !bus.mem_ready;
  assign advance    = bus.run && (state_q != S_HALT) && (!mem_step || bus.mem_ready);

  // An illegal opcode in ID traps even if the decoder also raised next_ins.
  assign trap_illegal = advance && (state_q == S_ID) && !legal_op;
  assign retire       = advance && !trap_illegal &&
                        ((state_q == S_WB) || (bus.next_ins && legal_step));

`ifdef MULTI_STATE_SEQ_STALL_TIMEOUT_EN
  localparam int STALL_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [STALL_W-1:0] stall_q;
  logic               timeout_q;

  assign trap_timeout = stalled && (stall_q == STALL_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (trap_timeout) timeout_q <= 1'b1;
      if (!bus.run || advance || trap_timeout) stall_q <= '0;
      else if (stalled)                        stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign trap_timeout = 1'b0;
  assign bus.timeout  = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every register in this
  // block samples pre-edge values; blocking here would leak new state into later lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IF;
      illegal_q  <= 1'b0;
      ins_done_q <= 1'b0;
      cycle_q    <= '0;
      instr_q    <= '0;
    end else begin
      ins_done_q <= retire;
      if (retire)                           instr_q <= instr_q + CNT_W'(1);
      if (bus.run && state_q != S_HALT)     cycle_q <= cycle_q + CNT_W'(1);
      if (trap_illegal)                     illegal_q <= 1'b1;

      if (trap_timeout || trap_illegal) begin
        state_q <= S_HALT;
      end else if (retire) begin
        state_q <= S_IF;
      end else if (advance) begin
        case (state_q)
          S_IF:    state_q <= S_ID;
          S_ID:    state_q <= S_EX;
          S_EX:    state_q <= S_MEM;
          S_MEM:   state_q <= S_WB;
          default: state_q <= S_IF;  // 110/111 upset recovery, never a retire
        endcase
      end
    end
  end

  assign bus.state     = state_q;
  assign bus.ctrl_kill = (state_q == S_HALT);
  assign bus.ins_done  = ins_done_q;
  assign bus.illegal   = illegal_q;
  assign bus.cycle_cnt = cycle_q;
  assign bus.instr_cnt = instr_q;

endmodule

// File: doc/multi_state_seq.md
Name: multi_state_seq

Overview:
- State sequencer for the multi-cycle MIPS CPU; the other end of the main decoder's `state`/`next_ins` interface.
- Owns the 3-bit step register the decoder reads:
  - advances one step per cycle;
  - returns to fetch when the decoder raises `next_ins`;
  - stalls on memory steps until memory is ready;
  - traps illegal opcodes into a halt state.
- Also keeps cycle and retired-instruction counters for the bench and the debug top.

Parameters:
- `CNT_W`, 32, width of `cycle_cnt` and `instr_cnt`.
- `TIMEOUT`, 255, maximum consecutive stall cycles before trap (used only with `STALL_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `run`  in  1  1 = sequence; 0 = freeze state and counters.
- `Op`  in  6  opcode field from the instruction register.
- `next_ins`  in  1  decoder request to return to IF at the next edge.
- `mem_ready`  in  1  memory has completed the current access.
- `state`  out  3  current step to the decoder: 000 IF, 001 ID, 010 EX, 011 MEM, 100 WB, 101 HALT.
- `ctrl_kill`  out  1  1 in HALT; top ANDs all decoder write enables with `~ctrl_kill`.
- `ins_done`  out  1  registered one-cycle pulse per retired instruction.
- `illegal`  out  1  sticky; set on an illegal opcode trap.
- `timeout`  out  1  sticky; set on a stall-timeout trap (constant 0 without the macro).
- `cycle_cnt`  out  `CNT_W`  cycles with `run`=1 and not HALT.
- `instr_cnt`  out  `CNT_W`  retired instructions.

Behaviour:
- Reset (async, `rst_n`=0): `state`=IF; `ins_done`, `illegal`, `timeout`, `ctrl_kill` = 0; both counters = 0; stall counter = 0. Release is sampled at the next rising edge; reset mid-instruction abandons it, with no retire.
- Step is "memory" when `state`==IF, or `state`==MEM with `Op` = lw (100011) or sw (101011).
- `advance` = `run` & `state`!=HALT & (not memory step | `mem_ready`).
- Legal opcodes: 000000, 100011, 101011, 000100, 001000, 000010.
- Transitions, taken only when `advance`=1; otherwise `state` holds:
  - ID with illegal `Op` -> HALT; `illegal` set at the same edge.
  - `next_ins`=1 in any legal step -> IF; this is a retire.
  - WB -> IF regardless of `next_ins`; this is a retire.
  - Otherwise `state`+1.
  - Encodings 110/111 (unreachable; SEU guard) -> IF, no retire.
- Retire edge: `instr_cnt`+1 and `ins_done`=1 for exactly the following cycle. Retires are at most one per cycle, so back-to-back retires give contiguous `ins_done` high cycles.
- Resulting cycle counts, no stalls:
  - beq / j: 3 cycles.
  - R-type / sw / addi: 4 cycles.
  - lw: 5 cycles.
- `cycle_cnt` increments on every edge with `run`=1 and `state`!=HALT, including stall cycles.
- Both counters wrap modulo 2^`CNT_W` silently.
- HALT: absorbing until reset; `ctrl_kill`=1 combinationally from `state`; counters frozen; `next_ins`/`mem_ready` ignored.
- `run`=0: nothing changes except `ins_done`, which clears. Dropping `run` during a stall keeps the stall step.
- `ctrl_kill` is decoded from `state`; all other outputs are registered.

Optional Feature:
- Macro: `MULTI_STATE_SEQ_STALL_TIMEOUT_EN`.
- With the macro:
  - A stall counter (8 bits minimum, sized to hold `TIMEOUT`) increments each cycle that `run`=1, the step is a memory step, and `mem_ready`=0.
  - It clears on any `advance` or when `run`=0.
  - When it reaches `TIMEOUT` while still stalled, the next edge goes to HALT with `timeout`=1.
- Without the macro: stalls are unbounded, no stall counter is instantiated, and `timeout` is tied 0.

Test Plan:
- Reset, then `run`=1, `mem_ready`=1, R-type with `next_ins` as the decoder drives -> `state` sequence 0,1,2,3,0; `ins_done` pulses once; `instr_cnt`=1, `cycle_cnt`=4.
- lw then beq back-to-back, `mem_ready`=1 -> states 0,1,2,3,4,0,1,2,0; `instr_cnt`=2, `cycle_cnt`=8.
- sw with `mem_ready` low 3 cycles in MEM -> `state` holds 011 for 4 cycles; retire after 7 cycles total; `cycle_cnt`=7.
- `Op`=111111 reaching ID -> next edge `state`=101, `illegal`=1, `ctrl_kill`=1; counters frozen for 20 further cycles.
- `rst_n` asserted asynchronously in EX -> `state`=000 immediately, counters 0; `run` toggled 0 for 5 cycles mid-instruction -> `state` and `cycle_cnt` unchanged.
- With the macro, `TIMEOUT`=4, `mem_ready`=0 in IF -> HALT with `timeout`=1 after 5 cycles; without the macro -> still in IF after 1000 cycles, `timeout`=0.
